// File: rtl/ma_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : ma_pkg                                                    |
// | Description: Shared types and helper functions for the sliding-window  |
// |              moving average (state encoding, accumulator sizing and    |
// |              window-select clamping).                                  |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package ma_pkg;

  // FILL: history not yet full, no results produced (except at the fill point).
  // RUN : window full, every accept slides the window by one sample.
  typedef enum logic [0:0] {
    MA_FILL = 1'b0,
    MA_RUN  = 1'b1
  } ma_state_e;

  // Sum of 2**log2_depth samples of data_w bits never needs more than this.
  function automatic int ma_acc_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Window exponents beyond the ring depth saturate at the deepest window.
  function automatic int ma_clamp_sel(input int sel, input int max_sel);
    return (sel > max_sel) ? max_sel : sel;
  endfunction

endpackage : ma_pkg
`default_nettype wire

// File: rtl/ma_history_ring.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : ma_history_ring                                           |
// | Description: Sample history for the moving average. Register array     |
// |              with one synchronous write port and one combinational     |
// |              read port. Contents are not reset: every location is      |
// |              written before the averager ever reads it.                |
// | Ports      : clk   - clock                                             |
// |              we    - write enable                                      |
// |              waddr - write address                                     |
// |              wdata - write data                                        |
// |              raddr - read address                                      |
// |              rdata - read data (combinational, pre-write value)        |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module ma_history_ring #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int C_DEPTH = 2 ** LOG2_DEPTH;

  logic [DATA_W-1:0] r_mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // When the window equals the full depth, raddr == waddr; the read returns
  // the sample being overwritten, which is exactly the one leaving the window.
  assign rdata = r_mem[raddr];

endmodule : ma_history_ring
`default_nettype wire

// File: rtl/moving_average_window.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : moving_average_window                                     |
// | Description: Exact boxcar moving average over a runtime-selectable     |
// |              power-of-two window (1..2**LOG2_MAX_DEPTH) with a         |
// |              valid/ready input, optional decimation and automatic      |
// |              flush when the window or the clear input changes.         |
// | Ports      : clk, rst_n (async, active low)                            |
// |              enable    - 0 freezes all state                           |
// |              clear     - synchronous flush                             |
// |              win_sel   - window exponent, clamped to LOG2_MAX_DEPTH    |
// |              decimate  - 1: one result per N accepted samples          |
// |              in_valid/in_ready/in_data - sample input handshake        |
// |              out_valid - one-cycle result strobe                       |
// |              out_data  - rounded mean (held between strobes)           |
// |              out_full  - window is full                                |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module moving_average_window
  import ma_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int LOG2_MAX_DEPTH = 4,
  parameter int SEL_W          = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [SEL_W-1:0]         win_sel,
  input  logic                     decimate,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_full
);

  localparam int ACC_W = ma_acc_w(DATA_W, LOG2_MAX_DEPTH);
  localparam int CNT_W = LOG2_MAX_DEPTH + 1;  // holds N itself
  localparam int RND_W = ACC_W + 1;           // headroom for the rounding add
  localparam int PTR_W = LOG2_MAX_DEPTH;

  // ---------------------------------------------------------------- state
  ma_state_e                r_state;
  logic signed [ACC_W-1:0]  r_sum;
  logic [CNT_W-1:0]         r_fill;
  logic [CNT_W-1:0]         r_phase;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [SEL_W-1:0]         r_win_q;

  // ---------------------------------------------------------------- control
  logic [SEL_W-1:0]         w_sel_eff;
  logic                     w_sel_match;
  logic                     w_flush;
  logic                     w_accept;
  logic [CNT_W-1:0]         w_n;

  assign w_sel_eff   = SEL_W'(ma_clamp_sel(int'(win_sel), LOG2_MAX_DEPTH));
  assign w_sel_match = (w_sel_eff == r_win_q);
  assign w_n         = CNT_W'(1) << r_win_q;

  // A pending window change or clear blocks input for the flush cycle.
  assign in_ready = enable & ~clear & w_sel_match;
  assign w_flush  = enable & (clear | ~w_sel_match);
  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------- history
  logic [PTR_W-1:0]         w_raddr;
  logic [DATA_W-1:0]        w_old;

  assign w_raddr = r_wr_ptr - w_n[PTR_W-1:0];

  ma_history_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_MAX_DEPTH)
  ) u_ring (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (w_raddr),
    .rdata (w_old)
  );

  // ---------------------------------------------------------------- datapath
  logic signed [ACC_W-1:0]  w_x_ext;
  logic signed [ACC_W-1:0]  w_old_ext;
  logic signed [ACC_W-1:0]  w_sum_next;
  logic signed [RND_W-1:0]  w_half;
  logic signed [RND_W-1:0]  w_sum_rnd;
  logic signed [RND_W-1:0]  w_avg;
  logic                     w_unused_avg_hi;

  assign w_x_ext   = {{LOG2_MAX_DEPTH{in_data[DATA_W-1]}}, in_data};
  assign w_old_ext = {{LOG2_MAX_DEPTH{w_old[DATA_W-1]}}, w_old};

  // In FILL nothing has left the window yet, so nothing is subtracted.
  assign w_sum_next = (r_state == MA_RUN) ? (r_sum + w_x_ext - w_old_ext)
                                          : (r_sum + w_x_ext);

  // Adding N/2 then arithmetic-shifting rounds half toward +inf; for N=1 the
  // half term is zero and the shift is zero, giving the sum unchanged.
  assign w_half    = RND_W'(w_n >> 1);
  assign w_sum_rnd = {w_sum_next[ACC_W-1], w_sum_next} + w_half;
  assign w_avg     = w_sum_rnd >>> r_win_q;

  // The mean of DATA_W-bit samples always fits DATA_W; upper bits are sign copies.
  assign w_unused_avg_hi = ^w_avg[RND_W-1:DATA_W];

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0]         w_fill_inc;
  logic [CNT_W-1:0]         w_phase_inc;
  logic                     w_fill_done;
  logic                     w_phase_wrap;
  logic                     w_pulse;

  assign w_fill_inc   = r_fill + 1'b1;
  assign w_phase_inc  = r_phase + 1'b1;
  assign w_fill_done  = (w_fill_inc == w_n);
  assign w_phase_wrap = (w_phase_inc == w_n);

  // Phase and fill both restart at a flush, so a phase wrap never occurs
  // before the window is full.
  assign w_pulse = decimate ? w_phase_wrap
                            : ((r_state == MA_RUN) | w_fill_done);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MA_FILL;
      r_sum     <= '0;
      r_fill    <= '0;
      r_phase   <= '0;
      r_wr_ptr  <= '0;
      r_win_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (w_flush) begin
        // Write pointer is deliberately kept; stale history is never read
        // because FILL refills the whole window first.
        r_state <= MA_FILL;
        r_sum   <= '0;
        r_fill  <= '0;
        r_phase <= '0;
        r_win_q <= w_sel_eff;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_sum    <= w_sum_next;
        r_phase  <= w_phase_wrap ? '0 : w_phase_inc;
        if (r_state == MA_FILL) begin
          r_fill <= w_fill_inc;
          if (w_fill_done) begin
            r_state <= MA_RUN;
          end
        end
        if (w_pulse) begin
          out_valid <= 1'b1;
          out_data  <= w_avg[DATA_W-1:0];
        end
      end
    end
  end

  assign out_full = (r_state == MA_RUN);

endmodule : moving_average_window
`default_nettype wire

// File: tb/tb_moving_average_window.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_moving_average_window                                  |
// | Description: Scoreboard bench for moving_average_window. The driver    |
// |              pushes each expected result when it issues the sample     |
// |              that should produce it; a monitor pops on every out_valid.|
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_moving_average_window;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               clear;
  logic [2:0]         win_sel;
  logic               decimate;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_full;

  int checks    = 0;
  int failures  = 0;
  int pulse_cnt = 0;
  int exp_q[$];

  moving_average_window #(
    .DATA_W         (16),
    .LOG2_MAX_DEPTH (4),
    .SEL_W          (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .win_sel   (win_sel),
    .decimate  (decimate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_full  (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes one expected value per result strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got out_data=%0d expected no pulse", out_data);
        end else begin
          check("pulse_data", int'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted (bounded).
  task automatic send(input logic signed [15:0] x);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Change the window and verify the single flush cycle blocks input.
  task automatic set_sel(input logic [2:0] sel);
    win_sel = sel;
    @(negedge clk);
    check("flush_in_ready", int'(in_ready), 0);
    tick();
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  int base;
  int model_hist[$];
  int msum;
  logic signed [15:0] rx;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    win_sel  = 3'd0;
    decimate = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_full", int'(out_full), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    tick();

    // ---- Test 1: N=4, per-sample output
    base = pulse_cnt;
    set_sel(3'd2);
    send(16'sd4);
    send(16'sd8);
    send(16'sd12);
    check("t1_full_before", int'(out_full), 0);
    exp_q.push_back(10);
    send(16'sd16);
    check("t1_full_after", int'(out_full), 1);
    exp_q.push_back(14);
    send(16'sd20);
    settle();
    check("t1_pulses", pulse_cnt - base, 2);

    // ---- Test 2: N=2, rounding half toward +inf
    base = pulse_cnt;
    set_sel(3'd1);
    send(-16'sd3);
    exp_q.push_back(-2);
    send(-16'sd2);
    exp_q.push_back(0);
    send(16'sd1);
    exp_q.push_back(2);
    send(16'sd2);
    settle();
    check("t2_pulses", pulse_cnt - base, 3);

    // ---- Test 3: N=16, decimated, full-scale values
    base = pulse_cnt;
    decimate = 1'b1;
    set_sel(3'd4);
    for (int i = 0; i < 32; i++) begin
      if (i == 15 || i == 31) exp_q.push_back(32767);
      send(16'sd32767);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(-32768);
      send(-16'sd32768);
    end
    settle();
    check("t3_pulses", pulse_cnt - base, 3);

    // ---- Test 4: window change mid-stream flushes history
    base = pulse_cnt;
    decimate = 1'b0;
    set_sel(3'd3);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(45);
      send(16'(i * 10));
    end
    exp_q.push_back(55);
    send(16'sd90);
    settle();
    check("t4_full_run", int'(out_full), 1);
    win_sel = 3'd2;
    @(negedge clk);
    check("t4_change_in_ready", int'(in_ready), 0);
    tick();
    check("t4_full_flushed", int'(out_full), 0);
    send(16'sd1);
    send(16'sd2);
    send(16'sd3);
    check("t4_full_refill", int'(out_full), 0);
    exp_q.push_back(3);
    send(16'sd4);
    settle();
    check("t4_pulses", pulse_cnt - base, 3);

    // ---- Test 5: clear beats in_valid; enable=0 freezes everything
    base = pulse_cnt;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd100;
    @(negedge clk);
    check("t5_clear_in_ready", int'(in_ready), 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_clear_full", int'(out_full), 0);
    send(16'sd1);
    send(16'sd1);
    send(16'sd1);
    exp_q.push_back(1);
    send(16'sd1);
    settle();
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'sd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_dis_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    check("t5_dis_full_hold", int'(out_full), 1);
    check("t5_dis_data_hold", int'(out_data), 1);
    enable = 1'b1;
    exp_q.push_back(2);
    send(16'sd5);
    settle();
    check("t5_pulses", pulse_cnt - base, 2);

    // ---- Test 6: win_sel=7 clamps to N=16; random stream vs model
    base = pulse_cnt;
    set_sel(3'd7);
    @(negedge clk);
    check("t6_clamp_in_ready", int'(in_ready), 1);
    tick();
    model_hist.delete();
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom_range(0, 65535));
      model_hist.push_back(int'(rx));
      if (model_hist.size() > 16) void'(model_hist.pop_front());
      if (model_hist.size() == 16) begin
        msum = 0;
        foreach (model_hist[j]) msum += model_hist[j];
        exp_q.push_back((msum + 8) >>> 4);
      end
      send(rx);
      if ($urandom_range(0, 3) == 0) tick();
    end
    settle();
    check("t6_pulses", pulse_cnt - base, 985);

    // ---- Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_full", int'(out_full), 0);
    check("rst_mid_out_data", int'(out_data), 0);
    check("rst_mid_out_valid", int'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    settle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_moving_average_window
`default_nettype wire
